// File: rtl/baggage_drop_ctrl_if.sv
// Handshake bundle between the baggage-drop sequencer and its environment
// (operator controls, belt sensor, display/drop decision block).
interface baggage_drop_ctrl_if;
   logic        cfg_we;
   logic [15:0] cfg_t_lim;
   logic        start;
   logic        abort;
   logic        bag_ready;
   logic        drop_activated;
   logic [15:0] t_act;
   logic [15:0] t_lim;
   logic        drop_en;
   logic        drop_cmd;
   logic        busy;
   logic [1:0]  result;
   logic        result_valid;

   modport master (
      output cfg_we, cfg_t_lim, start, abort, bag_ready, drop_activated,
      input  t_act, t_lim, drop_en, drop_cmd, busy, result, result_valid
   );

   modport slave (
      input  cfg_we, cfg_t_lim, start, abort, bag_ready, drop_activated,
      output t_act, t_lim, drop_en, drop_cmd, busy, result, result_valid
   );
endinterface

// File: rtl/baggage_drop_ctrl.sv
// Baggage-drop station sequencer: times bag placement, requests a drop decision,
// then pulses the actuator or holds the reject verdict before returning to idle.
module baggage_drop_ctrl #(
   parameter int unsigned TICK_DIV    = 1000,
   parameter int unsigned DROP_CYCLES = 8,
   parameter logic [15:0] T_LIM_RESET = 16'd100
) (
   input  logic              clk,
   input  logic              rst_n,
   baggage_drop_ctrl_if.slave bus
);

   localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int unsigned HW = (DROP_CYCLES > 1) ? $clog2(DROP_CYCLES) : 1;

   localparam logic [1:0] ResDrop   = 2'b01;
   localparam logic [1:0] ResReject = 2'b10;
   localparam logic [1:0] ResAbort  = 2'b11;

   typedef enum logic [2:0] {StIdle, StMeasure, StDecide, StDrop, StReject} state_e;

   state_e      state_q, state_d;
   logic [PW-1:0] presc_q, presc_d;
   logic [HW-1:0] hold_q, hold_d;
   logic [15:0] t_act_q, t_act_d;
   logic [15:0] t_lim_q, t_lim_d;
   logic [1:0]  result_q, result_d;
   logic        rv_q, rv_d;
   logic        drop_en_q, drop_en_d;
   logic        drop_cmd_q, drop_cmd_d;
   logic        busy_q, busy_d;
   logic        tick;
   logic        hold_last;

   assign tick      = (presc_q == PW'(TICK_DIV - 1));
   assign hold_last = (hold_q == HW'(DROP_CYCLES - 1));

   always_comb begin
      state_d  = state_q;
      presc_d  = presc_q;
      hold_d   = hold_q;
      t_act_d  = t_act_q;
      t_lim_d  = t_lim_q;
      result_d = result_q;
      rv_d     = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (bus.cfg_we) t_lim_d = bus.cfg_t_lim;
            if (bus.start) begin
               t_act_d = '0;
               presc_d = '0;
               state_d = StMeasure;
            end
         end
         StMeasure: begin
            // The tick is applied even on the cycle the bag arrives
            if (tick) begin
               presc_d = '0;
               if (t_act_q != 16'hFFFF) t_act_d = t_act_q + 16'd1;
            end else begin
               presc_d = presc_q + PW'(1);
            end
            if (bus.abort) begin
               state_d  = StIdle;
               result_d = ResAbort;
               rv_d     = 1'b1;
            end else if (bus.bag_ready) begin
               state_d = StDecide;
            end
         end
         StDecide: begin
            hold_d = '0;
            if (bus.abort) begin
               state_d  = StIdle;
               result_d = ResAbort;
               rv_d     = 1'b1;
            end else if (bus.drop_activated) begin
               state_d = StDrop;
            end else begin
               state_d = StReject;
            end
         end
         StDrop, StReject: begin
            if (hold_last) begin
               state_d  = StIdle;
               result_d = (state_q == StDrop) ? ResDrop : ResReject;
               rv_d     = 1'b1;
            end else begin
               hold_d = hold_q + HW'(1);
            end
         end
         default: state_d = StIdle;
      endcase

      busy_d     = (state_d != StIdle);
      drop_en_d  = (state_d == StDecide) || (state_d == StDrop) || (state_d == StReject);
      drop_cmd_d = (state_d == StDrop);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= StIdle;
         presc_q    <= '0;
         hold_q     <= '0;
         t_act_q    <= '0;
         t_lim_q    <= T_LIM_RESET;
         result_q   <= 2'b00;
         rv_q       <= 1'b0;
         drop_en_q  <= 1'b0;
         drop_cmd_q <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         presc_q    <= presc_d;
         hold_q     <= hold_d;
         t_act_q    <= t_act_d;
         t_lim_q    <= t_lim_d;
         result_q   <= result_d;
         rv_q       <= rv_d;
         drop_en_q  <= drop_en_d;
         drop_cmd_q <= drop_cmd_d;
         busy_q     <= busy_d;
      end
   end

   assign bus.t_act        = t_act_q;
   assign bus.t_lim        = t_lim_q;
   assign bus.result       = result_q;
   assign bus.result_valid = rv_q;
   assign bus.drop_en      = drop_en_q;
   assign bus.drop_cmd     = drop_cmd_q;
   assign bus.busy         = busy_q;

endmodule

// File: doc/baggage_drop_ctrl.md
# baggage_drop_ctrl

Sequencer for the baggage-drop station. It measures how long a passenger takes to place a bag, freezes that time as `t_act`, and drives `drop_en` into the display/drop decision block. It reads back `drop_activated`, then either pulses the drop actuator or holds the reject indication before returning to idle. It also owns the configurable time limit `t_lim` feeding the same block.

## Interface
- `TICK_DIV`, 1000: clock cycles per time unit; must be ≥ 1.
- `DROP_CYCLES`, 8: cycles `drop_cmd` is held; also the reject hold length; must be ≥ 1.
- `T_LIM_RESET`, 16'd100: `t_lim` value after reset.

- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `cfg_we` in 1: load `cfg_t_lim` into `t_lim`; honoured only in IDLE.
- `cfg_t_lim` in 16: new limit, in time units.
- `start` in 1: begin a session; honoured only in IDLE.
- `abort` in 1: cancel the session; honoured in MEASURE and DECIDE only.
- `bag_ready` in 1: bag placed on the belt; level input, sampled in MEASURE.
- `drop_activated` in 1: decision from the display/drop block; sampled in DECIDE.
- `t_act` out 16: measured time, registered.
- `t_lim` out 16: current limit, registered.
- `drop_en` out 1: drop request to the display/drop block.
- `drop_cmd` out 1: actuator command.
- `busy` out 1: high whenever the state is not IDLE.
- `result` out 2: outcome of the last session. 00 none, 01 dropped, 10 rejected (over limit), 11 aborted.
- `result_valid` out 1: one-cycle pulse when `result` updates.

## Operation
- **Reset values:** state IDLE, `t_act`=0, `t_lim`=T_LIM_RESET, prescaler=0, hold counter=0. All other outputs are 0 (`drop_en`, `drop_cmd`, `busy`, `result`=00, `result_valid`).
- **States:** IDLE, MEASURE, DECIDE, DROP, REJECT.
- **IDLE**
  - `cfg_we` writes `t_lim`.
  - `start` clears `t_act` and the prescaler, then moves to MEASURE.
  - If `cfg_we` and `start` arrive together, both take effect; the session uses the new limit.
  - `t_act` and `result` keep their last values until the next `start`.
- **MEASURE**
  - The prescaler counts 0..TICK_DIV-1.
  - On wrap, `t_act` increments and saturates at 16'hFFFF.
  - `drop_en`=0.
  - `abort` returns to IDLE with `result`=11.
  - Otherwise `bag_ready`=1 moves to DECIDE and freezes `t_act`.
  - An increment due in the same cycle as `bag_ready` is kept.
  - `abort` takes priority over `bag_ready`.
- **DECIDE** (exactly one cycle)
  - `drop_en`=1.
  - `drop_activated`=1 moves to DROP; otherwise to REJECT.
  - `abort` in this cycle wins: go to IDLE, `result`=11.
- **DROP**
  - `drop_en`=1 and `drop_cmd`=1 for DROP_CYCLES cycles.
  - Then IDLE with `result`=01.
  - `abort` is ignored; the actuator always completes.
- **REJECT**
  - `drop_en`=1 and `drop_cmd`=0 for DROP_CYCLES cycles, so the display holds its verdict.
  - Then IDLE with `result`=10.
  - `abort` is ignored.
- **Config and start outside IDLE:** `cfg_we` and `start` are ignored; `t_lim` stays constant for the whole session.
- **Decision boundaries:**
  - `t_act` == `t_lim` is a drop.
  - `t_lim`=0 drops only if `bag_ready` arrives before the first tick.
  - `t_lim`=16'hFFFF always drops.
- **Asynchronous reset mid-session:** the state machine goes straight to IDLE with reset values. `drop_cmd` drops immediately; no `result_valid` is produced.

## Timing
- `start` sampled at edge N: MEASURE and `busy`=1 from N+1.
- First `t_act` increment at N+TICK_DIV; thereafter one increment every TICK_DIV cycles.
- `bag_ready` sampled at edge M: DECIDE with `drop_en`=1 in cycle M+1.
- DROP/REJECT occupies cycles M+2 .. M+1+DROP_CYCLES.
- IDLE from M+2+DROP_CYCLES. In that cycle `busy`=0, `drop_en`=0, `result` is updated and `result_valid`=1.
- Abort sampled at edge A: IDLE, `result`=11 and `result_valid`=1 in cycle A+1.
- All outputs are registered. `drop_activated` comes from a combinational block and is valid in the same DECIDE cycle.
- A `start` seen in the first IDLE cycle (while `result_valid`=1) is honoured.

## Test plan
- **Drop within limit.** TICK_DIV=4, DROP_CYCLES=3, `t_lim`=5; `start`, then `bag_ready` after 12 cycles. Required: `t_act`=3, `drop_en` pulse, `drop_cmd` high exactly 3 cycles, `result`=01 with a single `result_valid`.
- **Over limit.** `t_lim`=2, `bag_ready` after 20 cycles with the display model returning `drop_activated`=0. Required: `drop_cmd` never high, `drop_en` high for 4 cycles, `result`=10.
- **Equality and saturation.**
  - `t_act`==`t_lim`=3: required drop.
  - TICK_DIV=1 with `t_lim`=16'hFFFF, run 70000 cycles: required `t_act` stays at FFFF and the session drops.
- **Abort.**
  - Abort in MEASURE: required `result`=11 next cycle.
  - Abort during DROP: required to be ignored, with the full 3-cycle `drop_cmd`.
  - Abort in the same cycle as `bag_ready`: required aborted.
- **Config gating.**
  - `cfg_we`=1 with `cfg_t_lim`=7 in MEASURE: required `t_lim` unchanged.
  - `cfg_we`+`start` together in IDLE: required `t_lim`=7 used for the session.
- **Reset mid-DROP.** Assert `rst_n` low in DROP cycle 2. Required: `drop_cmd`=0 asynchronously, `t_lim`=100, `result`=00, no `result_valid`.
